// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-master arbiter in front of the single data RAM
//
// Purpose:
//   Shares one registered-output RAM between the CPU data port and a second
//   bus master (DMA / debug loader). Every access runs IDLE -> ACCESS -> RESP
//   and returns to IDLE for at least one cycle, so the RAM sees exactly one
//   enable per access. Contention is resolved round-robin: when both masters
//   request in IDLE, the one that did not win the previous grant is served.
//
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   cpu_req_i / dma_req_i          access request, held until the matching ack
//   cpu_we_i / dma_we_i            1 = write, 0 = read
//   cpu_addr_i / dma_addr_i        access address
//   cpu_wdata_i / dma_wdata_i      write data
//   cpu_ack_o / dma_ack_o          one-cycle completion pulse (RESP cycle)
//   cpu_rdata_o / dma_rdata_o      read data, non-zero only with ack on a read
//   ram_addr_o, ram_data_in_o      RAM address / write data, held between accesses
//   ram_write_enable_o             RAM write strobe (ACCESS cycle of a write)
//   ram_read_enable_o              RAM read strobe (ACCESS cycle of a read)
//   ram_data_out_i                 RAM read data, valid the cycle after the read strobe
//   grant_o                        one-hot owner: bit0 = CPU, bit1 = DMA, 00 = none

module ram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  reset_i,

   input  logic                  cpu_req_i,
   input  logic                  cpu_we_i,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
   output logic                  cpu_ack_o,
   output logic [DATA_WIDTH-1:0] cpu_rdata_o,

   input  logic                  dma_req_i,
   input  logic                  dma_we_i,
   input  logic [ADDR_WIDTH-1:0] dma_addr_i,
   input  logic [DATA_WIDTH-1:0] dma_wdata_i,
   output logic                  dma_ack_o,
   output logic [DATA_WIDTH-1:0] dma_rdata_o,

   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_data_in_o,
   output logic                  ram_write_enable_o,
   output logic                  ram_read_enable_o,
   input  logic [DATA_WIDTH-1:0] ram_data_out_i,

   output logic [1:0]            grant_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t                state_q,      state_d;
   logic                  owner_dma_q,  owner_dma_d;   // 0 = CPU owns, 1 = DMA owns
   logic                  owner_we_q,   owner_we_d;    // owner's we captured at grant
   logic                  prio_dma_q,   prio_dma_d;    // 1 = DMA wins the next tie
   logic [ADDR_WIDTH-1:0] ram_addr_q,   ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q,  ram_wdata_d;

   // DMA wins if it is the only requester, or if both request and it is DMA's turn.
   logic win_dma;
   assign win_dma = dma_req_i & (~cpu_req_i | prio_dma_q);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         owner_dma_q <= 1'b0;
         owner_we_q  <= 1'b0;
         prio_dma_q  <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_dma_q <= owner_dma_d;
         owner_we_q  <= owner_we_d;
         prio_dma_q  <= prio_dma_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   // Next-state logic. Requests are only looked at in IDLE; the owner's
   // address and data are captured at grant time so the RAM bus is already
   // stable for the whole ACCESS cycle and simply holds afterwards.
   always_comb begin
      state_d     = state_q;
      owner_dma_d = owner_dma_q;
      owner_we_d  = owner_we_q;
      prio_dma_d  = prio_dma_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cpu_req_i || dma_req_i) begin
               state_d     = ST_ACCESS;
               owner_dma_d = win_dma;
               prio_dma_d  = ~win_dma;
               if (win_dma) begin
                  owner_we_d  = dma_we_i;
                  ram_addr_d  = dma_addr_i;
                  ram_wdata_d = dma_wdata_i;
               end else begin
                  owner_we_d  = cpu_we_i;
                  ram_addr_d  = cpu_addr_i;
                  ram_wdata_d = cpu_wdata_i;
               end
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded purely from registered state, owner and captured we,
   // so strobes and acks change only on clock edges (or on reset).
   logic in_access;
   logic in_resp;
   logic busy;

   always_comb begin
      in_access = (state_q == ST_ACCESS);
      in_resp   = (state_q == ST_RESP);
      busy      = in_access | in_resp;

      grant_o            = 2'b00;
      ram_write_enable_o = 1'b0;
      ram_read_enable_o  = 1'b0;
      cpu_ack_o          = 1'b0;
      dma_ack_o          = 1'b0;
      cpu_rdata_o        = '0;
      dma_rdata_o        = '0;

      if (busy) begin
         grant_o = owner_dma_q ? 2'b10 : 2'b01;
      end

      if (in_access) begin
         ram_write_enable_o = owner_we_q;
         ram_read_enable_o  = ~owner_we_q;
      end

      if (in_resp) begin
         cpu_ack_o = ~owner_dma_q;
         dma_ack_o = owner_dma_q;
         // The RAM registered the read at the end of ACCESS, so its output is
         // valid now; it is steered only to the owner and only for a read.
         if (!owner_we_q) begin
            if (owner_dma_q) begin
               dma_rdata_o = ram_data_out_i;
            end else begin
               cpu_rdata_o = ram_data_out_i;
            end
         end
      end
   end

   assign ram_addr_o    = ram_addr_q;
   assign ram_data_in_o = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a transaction-level reference model

module tb_ram_arbiter;

   localparam int MAXC = 8192;

   typedef struct {
      int          cyc;
      logic        we;
      logic [31:0] rdata;
   } resp_t;

   typedef struct {
      int          cyc;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } ramop_t;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        req   [2];
   logic        we    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];

   logic        cpu_ack, dma_ack;
   logic [31:0] cpu_rdata, dma_rdata;
   logic [31:0] ram_addr, ram_data_in, ram_data_out;
   logic        ram_we, ram_re;
   logic [1:0]  grant;

   ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk_i              (clk),
      .reset_i            (rst),
      .cpu_req_i          (req[0]),
      .cpu_we_i           (we[0]),
      .cpu_addr_i         (addr[0]),
      .cpu_wdata_i        (wdata[0]),
      .cpu_ack_o          (cpu_ack),
      .cpu_rdata_o        (cpu_rdata),
      .dma_req_i          (req[1]),
      .dma_we_i           (we[1]),
      .dma_addr_i         (addr[1]),
      .dma_wdata_i        (wdata[1]),
      .dma_ack_o          (dma_ack),
      .dma_rdata_o        (dma_rdata),
      .ram_addr_o         (ram_addr),
      .ram_data_in_o      (ram_data_in),
      .ram_write_enable_o (ram_we),
      .ram_read_enable_o  (ram_re),
      .ram_data_out_i     (ram_data_out),
      .grant_o            (grant)
   );

   // RAM model: registered read, 256 words aliased on addr[7:0], with a backdoor port.
   logic [31:0] mem [256];
   logic        mem_clear;
   logic        bd_we;
   logic [7:0]  bd_addr;
   logic [31:0] bd_data;

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         ram_data_out <= '0;
      end else begin
         if (ram_we) mem[ram_addr[7:0]] <= ram_data_in;
         if (ram_re) ram_data_out <= mem[ram_addr[7:0]];
         if (bd_we)  mem[bd_addr] <= bd_data;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard shared by stimulus (push) and monitor (pop).
   resp_t       exp_q0[$];
   resp_t       exp_q1[$];
   ramop_t      ram_q[$];
   logic [1:0]  exp_grant [MAXC];
   int          rst_seq = 0;
   bit          done = 1'b0;

   // Reference model state: a transaction timeline, not a state machine.
   logic [31:0] ref_mem [256];
   bit          pend    [2];
   bit          granted [2];
   int          ack_cyc [2];
   int          free_cyc;
   int          last_w;
   bit          inf_v;
   logic [7:0]  inf_idx;
   logic [31:0] inf_old;
   int          inf_cyc;

   task automatic retire();
      for (int m = 0; m < 2; m++) begin
         if (pend[m] && granted[m] && cyc == ack_cyc[m] + 1) begin
            pend[m]    = 1'b0;
            granted[m] = 1'b0;
            req[m]     = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      retire();
   endtask

   task automatic post(int m, logic w, logic [31:0] a, logic [31:0] d);
      req[m]     = 1'b1;
      we[m]      = w;
      addr[m]    = a;
      wdata[m]   = d;
      pend[m]    = 1'b1;
      granted[m] = 1'b0;
   endtask

   task automatic post_rand(int m);
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'h3F;
      post(m, 1'($urandom_range(0, 1)), a, $urandom);
   endtask

   // One arbitration decision per free cycle: a grant made in cycle c means
   // RAM access in c+1, ack in c+2, arbiter available again in c+3.
   task automatic model();
      bit          c0, c1;
      int          w;
      logic [7:0]  idx;
      logic [31:0] rd;
      if (cyc < free_cyc) return;
      c0 = pend[0] && !granted[0];
      c1 = pend[1] && !granted[1];
      if (!(c0 || c1)) return;
      if (c0 && c1) w = 1 - last_w;
      else          w = c1 ? 1 : 0;
      idx        = addr[w][7:0];
      granted[w] = 1'b1;
      ack_cyc[w] = cyc + 2;
      free_cyc   = cyc + 3;
      last_w     = w;
      exp_grant[cyc + 1] = (w == 1) ? 2'b10 : 2'b01;
      exp_grant[cyc + 2] = (w == 1) ? 2'b10 : 2'b01;
      ram_q.push_back('{cyc: cyc + 1, we: we[w], addr: addr[w], wdata: wdata[w]});
      rd = we[w] ? 32'h0 : ref_mem[idx];
      if (we[w]) begin
         inf_v   = 1'b1;
         inf_idx = idx;
         inf_old = ref_mem[idx];
         inf_cyc = cyc + 1;
         ref_mem[idx] = wdata[w];
      end
      if (w == 0) exp_q0.push_back('{cyc: cyc + 2, we: we[w], rdata: rd});
      else        exp_q1.push_back('{cyc: cyc + 2, we: we[w], rdata: rd});
   endtask

   // Reset asserted mid-cycle: in-flight work is lost, and a write whose
   // ACCESS cycle has not completed never reaches the RAM.
   task automatic do_reset();
      rst = 1'b1;
      rst_seq++;
      exp_q0.delete();
      exp_q1.delete();
      ram_q.delete();
      for (int k = 0; k < 4; k++) exp_grant[cyc + k] = 2'b00;
      if (inf_v && inf_cyc >= cyc) ref_mem[inf_idx] = inf_old;
      inf_v = 1'b0;
      for (int m = 0; m < 2; m++) begin
         pend[m]    = 1'b0;
         granted[m] = 1'b0;
         req[m]     = 1'b0;
      end
      last_w = 1;
      tick();
      rst      = 1'b0;
      free_cyc = cyc;
   endtask

   task automatic drain(int max);
      for (int i = 0; i < max && (pend[0] || pend[1]); i++) begin
         tick();
         model();
      end
   endtask

   // Stimulus
   initial begin
      int n;
      int np [2];
      rst = 1'b1;
      mem_clear = 1'b1;
      bd_we = 1'b0;
      bd_addr = '0;
      bd_data = '0;
      for (int m = 0; m < 2; m++) begin
         req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
         pend[m] = 1'b0; granted[m] = 1'b0; ack_cyc[m] = 0;
      end
      for (int i = 0; i < MAXC; i++) exp_grant[i] = 2'b00;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      last_w = 1;
      inf_v = 1'b0;
      free_cyc = 0;
      rst_seq = 1;
      repeat (3) tick();
      mem_clear = 1'b0;
      rst = 1'b0;
      free_cyc = cyc;

      // CPU write 0x10 then read it back
      tick(); post(0, 1'b1, 32'h10, 32'hDEADBEEF); model(); drain(20);
      tick(); post(0, 1'b0, 32'h10, 32'h0);        model(); drain(20);

      // DMA-only read of preloaded word
      bd_we = 1'b1; bd_addr = 8'h20; bd_data = 32'h12345678;
      ref_mem[8'h20] = 32'h12345678;
      tick();
      bd_we = 1'b0;
      post(1, 1'b0, 32'h20, 32'h0); model(); drain(20);

      // Simultaneous requests straight out of reset: CPU first
      tick(); do_reset();
      tick(); post(0, 1'b0, 32'h10, 32'h0); post(1, 1'b0, 32'h20, 32'h0); model(); drain(20);

      // Continuous contention: both re-present right after each ack
      np[0] = 0; np[1] = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         for (int m = 0; m < 2; m++) begin
            if (!pend[m] && np[m] < 3) begin
               post(m, 1'b1, 32'h50 + m * 8 + np[m], $urandom);
               np[m]++;
            end
         end
         model();
      end
      drain(20);

      // Reset landing in the ACCESS cycle of a CPU write to 0x30
      tick(); post(0, 1'b1, 32'h30, 32'hCAFEF00D); model();
      tick();
      do_reset();
      tick(); post(0, 1'b0, 32'h30, 32'h0); model(); drain(20);

      // Back-to-back single master: three writes
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (!pend[0] && n < 3) begin
            post(0, 1'b1, 32'h40 + n, $urandom);
            n++;
         end
         model();
      end
      drain(20);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         tick();
         if ($urandom_range(0, 499) == 0) do_reset();
         for (int m = 0; m < 2; m++) begin
            if (!pend[m] && $urandom_range(0, 3) != 0) post_rand(m);
         end
         model();
      end
      drain(30);
      repeat (4) tick();
      done = 1'b1;
   end

   // Monitor / checker
   int n_checks = 0;
   int n_fail   = 0;
   int rst_seen = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
   endtask

   task automatic mon_port(int m, logic ack, logic [31:0] rd);
      resp_t e;
      bit    have;
      string p;
      p    = (m == 0) ? "cpu" : "dma";
      have = (m == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      if (have) e = (m == 0) ? exp_q0[0] : exp_q1[0];
      if (ack) begin
         if (!have) begin
            flag({p, " unexpected ack"});
         end else begin
            if (m == 0) void'(exp_q0.pop_front());
            else        void'(exp_q1.pop_front());
            chk({p, " ack cycle"}, cyc, e.cyc);
            if (!e.we) chk({p, " rdata"}, rd, e.rdata);
         end
      end else begin
         chk({p, " rdata without ack"}, rd, 32'h0);
         if (have && e.cyc <= cyc) begin
            chk({p, " missing ack at cycle"}, 32'h0, e.cyc);
            if (m == 0) void'(exp_q0.pop_front());
            else        void'(exp_q1.pop_front());
         end
      end
   endtask

   initial begin
      ramop_t o;
      while (!done) begin
         @(negedge clk);
         if (done) break;
         chk("grant", {30'h0, grant}, {30'h0, exp_grant[cyc]});
         if (rst_seq != rst_seen) begin
            chk("reset ram_addr", ram_addr, 32'h0);
            chk("reset ram_data_in", ram_data_in, 32'h0);
            rst_seen = rst_seq;
         end
         mon_port(0, cpu_ack, cpu_rdata);
         mon_port(1, dma_ack, dma_rdata);
         if (ram_we && ram_re) flag("both ram enables");
         if (ram_we || ram_re) begin
            if (ram_q.size() == 0) begin
               flag("unexpected ram enable");
            end else begin
               o = ram_q.pop_front();
               chk("ram access cycle", cyc, o.cyc);
               chk("ram write_enable", {31'h0, ram_we}, {31'h0, o.we});
               chk("ram_addr", ram_addr, o.addr);
               chk("ram_data_in", ram_data_in, o.wdata);
            end
         end else if (ram_q.size() > 0 && ram_q[0].cyc <= cyc) begin
            chk("missing ram access at cycle", 32'h0, ram_q[0].cyc);
            void'(ram_q.pop_front());
         end
      end
      chk("leftover cpu responses", exp_q0.size(), 32'h0);
      chk("leftover dma responses", exp_q1.size(), 32'h0);
      chk("leftover ram accesses", ram_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
